clk_ena_prescaler: RTL

//  Prescaler that sits directly upstream of the 8-bit timer counter. Produces the

---
 rtl/clk_ena_prescaler_pkg.sv | 12 +
 rtl/clk_ena_prescaler_if.sv | 13 +
 rtl/clk_ena_prescaler.sv | 77 +++++++
 3 files changed

// File: rtl/clk_ena_prescaler_pkg.sv
// Shared timer constants: divider width, rate-select width and rate-select codes.
package clk_ena_prescaler_pkg;

  localparam int unsigned TMR_DIV_W = 4;
  localparam int unsigned TMR_SEL_W = 2;

  localparam logic [TMR_SEL_W-1:0] CKS_DIV2  = TMR_SEL_W'(0);
  localparam logic [TMR_SEL_W-1:0] CKS_DIV4  = TMR_SEL_W'(1);
  localparam logic [TMR_SEL_W-1:0] CKS_DIV8  = TMR_SEL_W'(2);
  localparam logic [TMR_SEL_W-1:0] CKS_DIV16 = TMR_SEL_W'(3);

endpackage

// File: rtl/clk_ena_prescaler_if.sv
// Control/status bundle between the timer register block and the prescaler.
interface clk_ena_prescaler_if;
  import clk_ena_prescaler_pkg::*;

  logic                 en;
  logic [TMR_SEL_W-1:0] cks;
  logic                 clk_ena;
  logic [TMR_SEL_W-1:0] cks_active;

  modport master (output en, output cks, input clk_ena, input cks_active);
  modport slave  (input en, input cks, output clk_ena, output cks_active);

endinterface

// File: rtl/clk_ena_prescaler.sv
// Timer prescaler: one-cycle clk_ena tick every 2^(cks+1) clocks, with the rate
// switched only at a divider wrap or while disabled so no frame is cut short.
module clk_ena_prescaler
  import clk_ena_prescaler_pkg::*;
#(
  parameter int unsigned DIV_W = TMR_DIV_W,
  parameter int unsigned SEL_W = TMR_SEL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clk_ena_prescaler_if.slave   bus
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [SEL_W-1:0] cks_q,     cks_d;
  logic             clk_ena_q, clk_ena_d;

  logic [DIV_W-1:0] tap_mask;
  logic [DIV_W-1:0] tap_pat;
  logic             tap_hit;
  logic             wrap;

  // Tap k fires when div_cnt[k:0] == 0111..1, i.e. bit k of div_cnt+1 is about to rise.
  always_comb begin
    tap_mask = '0;
    tap_pat  = '0;
    for (int unsigned i = 0; i < DIV_W; i++) begin
      tap_mask[i] = (i <= 32'(cks_q));
      tap_pat[i]  = (i <  32'(cks_q));
    end
    tap_hit = ((div_cnt_q & tap_mask) == tap_pat);
  end

  assign wrap = &div_cnt_q;

  always_comb begin
    div_cnt_d = '0;
    cks_d     = cks_q;
    clk_ena_d = 1'b0;
    if (bus.en) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      clk_ena_d = tap_hit;
    end
    // All-ones never matches any tap, so switching here cannot emit a stray tick.
    if (!bus.en || wrap) begin
      cks_d = SEL_W'(bus.cks);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_ena_q <= 1'b0;
    end else begin
      clk_ena_q <= clk_ena_d;
    end
  end

  assign bus.clk_ena    = clk_ena_q;
  assign bus.cks_active = TMR_SEL_W'(cks_q);

endmodule
